// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit slot has a blank guard phase (all anodes off) followed by a
// show phase (one anode low, digit code and decoder enable presented).
// New values are loaded into a shadow register with a ready/valid
// handshake and copied to the active register only at a frame wrap, so
// a frame never mixes old and new digits.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   iLoad/oReady  load handshake; accepted when iLoad & oReady
//   iValue        4 bits per digit, digit 0 in iValue[3:0] (rightmost)
//   iLzs          leading-zero suppression, captured with iValue
//   oAn           active-low anode selects, at most one low
//   oDigit, oEna  code and enable for the shared hex-to-segment decoder
//   oFrame        one-cycle pulse on the first cycle of each new frame
module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iValue,
    input  logic                  iLzs,
    output logic                  oReady,
    output logic [DIGITS-1:0]     oAn,
    output logic [3:0]            oDigit,
    output logic                  oEna,
    output logic                  oFrame
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SLOT_CYCLES);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0]    active_q, active_d;
    logic [DIGITS-1:0][3:0]    shadow_q, shadow_d;
    logic                      act_lzs_q, act_lzs_d;
    logic                      sh_lzs_q, sh_lzs_d;
    logic                      pending_q, pending_d;
    logic [DIGITS-1:0]         an_q, an_d;
    logic [3:0]                digit_q, digit_d;
    logic                      ena_q, ena_d;
    logic                      frame_q, frame_d;
    logic                      ready_q, ready_d;

    // lz[i]: active digits DIGITS-1 down to i are all zero
    logic [DIGITS-1:0]         lz;
    logic                      blank_end, show_end, wrap;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        act_lzs_d = act_lzs_q;
        shadow_d  = shadow_q;
        sh_lzs_d  = sh_lzs_q;
        pending_d = pending_q;
        frame_d   = 1'b0;
        lz        = '0;

        blank_end = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
        show_end  = (state_q == ST_SHOW)  && (cnt_q == SHOW_LAST);
        wrap      = show_end && (idx_q == IDX_LAST);

        if (blank_end) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
        end else if (show_end) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d   = cnt_q + CW'(1);
        end

        // Frame wrap: apply the shadow. A load on this same edge is refused
        // because pending is still set.
        if (wrap) begin
            frame_d = 1'b1;
            if (pending_q) begin
                active_d  = shadow_q;
                act_lzs_d = sh_lzs_q;
                pending_d = 1'b0;
            end
        end

        if (iLoad && !pending_q) begin
            shadow_d  = iValue;
            sh_lzs_d  = iLzs;
            pending_d = 1'b1;
        end

        // Outputs are computed from next-state so the registered outputs
        // line up with the phase they belong to.
        lz[DIGITS-1] = (active_d[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--)
            lz[i] = lz[i+1] & (active_d[i] == 4'd0);

        an_d    = '1;
        digit_d = digit_q;
        ena_d   = 1'b0;
        if (state_d == ST_SHOW) begin
            an_d[idx_d] = 1'b0;
            digit_d     = active_d[idx_d];
            ena_d       = !(act_lzs_d && (idx_d != '0) && lz[idx_d]);
        end

        ready_d = ~pending_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BLANK;
            idx_q     <= '0;
            cnt_q     <= '0;
            active_q  <= '0;
            act_lzs_q <= 1'b0;
            shadow_q  <= '0;
            sh_lzs_q  <= 1'b0;
            pending_q <= 1'b0;
            an_q      <= '1;
            digit_q   <= '0;
            ena_q     <= 1'b0;
            frame_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            act_lzs_q <= act_lzs_d;
            shadow_q  <= shadow_d;
            sh_lzs_q  <= sh_lzs_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            digit_q   <= digit_d;
            ena_q     <= ena_d;
            frame_q   <= frame_d;
            ready_q   <= ready_d;
        end
    end

    assign oAn    = an_q;
    assign oDigit = digit_q;
    assign oEna   = ena_q;
    assign oFrame = frame_q;
    assign oReady = ready_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
// Expected per-slot {anode, digit, enable} entries are queued when a load
// is driven and popped when the frame showing that value is scanned.
module tb_seg7_scan_ctrl;

    localparam int D = 4;
    localparam int S = 8;
    localparam int B = 2;
    localparam int F = D * S;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iLoad = 1'b0;
    logic [15:0] iValue = '0;
    logic        iLzs = 1'b0;
    logic        oReady;
    logic [3:0]  oAn;
    logic [3:0]  oDigit;
    logic        oEna;
    logic        oFrame;
    bit          done = 1'b0;

    int checks = 0;
    int errs   = 0;

    typedef struct {
        logic [3:0] an;
        logic [3:0] dig;
        logic       ena;
    } exp_t;
    exp_t sb[$];

    seg7_scan_ctrl #(.DIGITS(D), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .iLoad(iLoad), .iValue(iValue), .iLzs(iLzs),
        .oReady(oReady), .oAn(oAn), .oDigit(oDigit), .oEna(oEna), .oFrame(oFrame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // At most one anode low in every cycle
    always @(negedge clk) if (!rst && !done) chk("an_onehot0", ($countones(~oAn) <= 1), 1);

    task automatic push_exp(input logic [15:0] v, input logic lzs);
        exp_t e;
        bit   allz;
        for (int i = 0; i < D; i++) begin
            allz = 1'b1;
            for (int j = i; j < D; j++) if (v[4*j +: 4] != 4'd0) allz = 1'b0;
            e.an  = ~(4'b0001 << i);
            e.dig = v[4*i +: 4];
            e.ena = !(lzs && (i != 0) && allz);
            sb.push_back(e);
        end
    endtask

    task automatic advance(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle load pulse; called and returns at a negedge
    task automatic load(input logic [15:0] v, input logic lzs);
        iLoad = 1'b1; iValue = v; iLzs = lzs;
        @(negedge clk);
        iLoad = 1'b0;
    endtask

    // Runs until the oFrame cycle; the still-active value must be shown
    // and the shadow must stay busy meanwhile.
    task automatic wait_frame(input logic [15:0] old);
        int slot;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (oFrame) return;
            chk("busy_ready", oReady, 0);
            if (oAn != 4'hF) begin
                slot = 0;
                for (int i = 0; i < D; i++) if (!oAn[i]) slot = i;
                chk("old_digit", oDigit, old[4*slot +: 4]);
            end
        end
        chk("frame_timeout", 0, 1);
    endtask

    // Called at the first cycle of a frame; scans one full frame.
    task automatic check_frame(input bit first);
        exp_t e[D];
        int   slot, ph;
        if (sb.size() < D) begin
            chk("sb_underflow", sb.size(), D);
            return;
        end
        for (int k = 0; k < D; k++) e[k] = sb.pop_front();
        for (int c = 0; c < F; c++) begin
            if (c > 0) @(negedge clk);
            slot = c / S;
            ph   = c % S;
            if (ph < B) begin
                chk("blank_an", oAn, 4'hF);
                chk("blank_ena", oEna, 0);
            end else begin
                chk("show_an", oAn, e[slot].an);
                chk("show_dig", oDigit, e[slot].dig);
                chk("show_ena", oEna, e[slot].ena);
            end
            chk("frame", oFrame, (c == 0 && !first));
            if (first && c == 0) begin
                chk("rst_digit", oDigit, 0);
                chk("rst_ready", oReady, 1);
            end
            if (c == 1) chk("ready_up", oReady, 1);
        end
    endtask

    initial begin
        // Reset, then two idle frames of "0000"
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        push_exp(16'h0000, 1'b0);
        check_frame(1'b1);
        @(negedge clk);
        push_exp(16'h0000, 1'b0);
        check_frame(1'b0);

        // Mid-frame load of 1234, then an ignored ABCD attempt
        advance(5);
        chk("ready_pre_load", oReady, 1);
        load(16'h1234, 1'b0);
        push_exp(16'h1234, 1'b0);
        chk("ready_drop", oReady, 0);
        load(16'hABCD, 1'b0);
        wait_frame(16'h0000);
        check_frame(1'b0);

        // Leading-zero suppression
        advance(3);
        load(16'h0050, 1'b1);
        push_exp(16'h0050, 1'b1);
        wait_frame(16'h1234);
        check_frame(1'b0);
        advance(3);
        load(16'h0000, 1'b1);
        push_exp(16'h0000, 1'b1);
        wait_frame(16'h0050);
        check_frame(1'b0);

        // Load held across the transfer edge is taken one cycle later
        advance(1);
        chk("ready_c0", oReady, 1);
        load(16'h7777, 1'b0);
        advance(F - 2);
        iLoad = 1'b1; iValue = 16'h8888; iLzs = 1'b0;
        chk("xfer_edge_ready", oReady, 0);
        @(negedge clk);
        chk("xfer_frame", oFrame, 1);
        chk("xfer_ready_up", oReady, 1);
        @(negedge clk);
        iLoad = 1'b0;
        chk("xfer_accept", oReady, 0);
        wait_frame(16'h7777);
        push_exp(16'h8888, 1'b0);
        check_frame(1'b0);

        // Reset during slot 2 SHOW with a pending load
        advance(1);
        load(16'h9999, 1'b1);
        advance(2 * S + B + 1);
        chk("pre_rst_an", oAn, 4'b1011);
        chk("pre_rst_ready", oReady, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_an", oAn, 4'hF);
        chk("rst_ena", oEna, 0);
        push_exp(16'h0000, 1'b0);
        check_frame(1'b1);
        @(negedge clk);
        push_exp(16'h0000, 1'b0);
        check_frame(1'b0);

        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
